// File: rtl/cci_mpf_pipe_req_buf_pkg.sv
// Shared types and helpers for the pipelined request buffer.
package cci_mpf_pipe_req_buf_pkg;

    // Quiesce controller states: normal traffic, draining, drained and idle.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    // Bits needed to count 0..maxReqs outstanding requests.
    function automatic int cntWidth(input int maxReqs);
        return $clog2(maxReqs + 1);
    endfunction

    // Counter width for the default outstanding-request limit of 128.
    localparam int DEFAULT_CNT_W = cntWidth(128);

endpackage

// File: rtl/cci_mpf_pipe_req_buf_chan.sv
// One request channel: a small FIFO plus a counter of issued-but-unretired requests.
module cci_mpf_pipe_req_buf_chan
    import cci_mpf_pipe_req_buf_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_SLACK = 8,
    parameter int MAX_ACTIVE_REQS   = 128,
    parameter int CNT_W             = cntWidth(MAX_ACTIVE_REQS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wrValid,
    input  logic [DATA_WIDTH-1:0] i_wrData,
    input  logic                  i_forceAlmostFull,
    input  logic                  i_outAlmostFull,
    input  logic                  i_retire,
    output logic                  o_almostFull,
    output logic                  o_issue,
    output logic [DATA_WIDTH-1:0] o_issueData,
    output logic [CNT_W-1:0]      o_activeCnt,
    output logic                  o_idle,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] THRESH = (AW+1)'(DEPTH - ALMOST_FULL_SLACK);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_rdPtr;
    logic [AW-1:0]         r_wrPtr;
    logic [AW:0]           r_count;
    logic [CNT_W-1:0]      r_active;
    logic                  r_almostFull;

    logic                  w_full;
    logic                  w_issue;
    logic                  w_push;
    logic [AW:0]           w_countNext;
    logic [CNT_W-1:0]      w_activeNext;
    logic                  w_underflow;

    // A full FIFO still takes a write when an entry leaves in the same cycle.
    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_issue     = (r_count != '0) && !i_outAlmostFull &&
                         (r_active < CNT_W'(MAX_ACTIVE_REQS));
    assign w_push      = i_wrValid && (!w_full || w_issue);
    assign w_countNext = r_count + (AW+1)'(w_push) - (AW+1)'(w_issue);

    assign o_issue      = w_issue;
    assign o_issueData  = r_mem[r_rdPtr];
    assign o_activeCnt  = r_active;
    assign o_almostFull = r_almostFull;
    assign o_idle       = (r_count == '0) && (r_active == '0);
    assign o_overflow   = i_wrValid && w_full && !w_issue;
    assign o_underflow  = w_underflow;

    // Outstanding count: issue adds one, retire removes one, a retire with nothing outstanding is an error.
    always_comb begin
        w_activeNext = r_active;
        w_underflow  = 1'b0;
        if (w_issue && !i_retire) begin
            w_activeNext = r_active + CNT_W'(1);
        end else if (!w_issue && i_retire) begin
            if (r_active == '0) begin
                w_underflow = 1'b1;
            end else begin
                w_activeNext = r_active - CNT_W'(1);
            end
        end
    end

    // Payload storage needs no reset; pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_wrData;
        end
    end

    // Pointers, occupancy, outstanding count and the registered backpressure flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdPtr      <= '0;
            r_wrPtr      <= '0;
            r_count      <= '0;
            r_active     <= '0;
            r_almostFull <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_issue) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count      <= w_countNext;
            r_active     <= w_activeNext;
            r_almostFull <= (w_countNext >= THRESH) || i_forceAlmostFull;
        end
    end

endmodule

// File: rtl/cci_mpf_pipe_req_buf.sv
// Multi-channel request buffer with per-channel outstanding limits and a quiesce controller.
module cci_mpf_pipe_req_buf
    import cci_mpf_pipe_req_buf_pkg::*;
#(
    parameter int N_CHANNELS        = 2,
    parameter int DATA_WIDTH        = 64,
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_SLACK = 8,
    parameter int MAX_ACTIVE_REQS   = 128
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [N_CHANNELS-1:0]                               in_valid,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0]                    in_data,
    output logic [N_CHANNELS-1:0]                               in_almost_full,
    output logic [N_CHANNELS-1:0]                               out_valid,
    output logic [N_CHANNELS*DATA_WIDTH-1:0]                    out_data,
    input  logic [N_CHANNELS-1:0]                               out_almost_full,
    input  logic [N_CHANNELS-1:0]                               rsp_retire,
    input  logic                                                quiesce_req,
    output logic                                                quiesce_ack,
    output logic [N_CHANNELS*cntWidth(MAX_ACTIVE_REQS)-1:0]     active_cnt,
    output logic                                                overflow_err,
    output logic                                                underflow_err
);

    localparam int CNT_W = cntWidth(MAX_ACTIVE_REQS);

    state_t                r_state;
    state_t                w_stateNext;
    logic                  r_quiesceAck;
    logic                  r_overflowErr;
    logic                  r_underflowErr;
    logic                  w_forceAlmostFull;
    logic [N_CHANNELS-1:0] w_chanIdle;
    logic [N_CHANNELS-1:0] w_chanOverflow;
    logic [N_CHANNELS-1:0] w_chanUnderflow;

    // Channels only block producers while leaving RUN; issue keeps going in DRAIN.
    assign w_forceAlmostFull = (w_stateNext != ST_RUN);

    genvar c;
    generate
        for (c = 0; c < N_CHANNELS; c++) begin : g_chan
            cci_mpf_pipe_req_buf_chan #(
                .DATA_WIDTH        (DATA_WIDTH),
                .DEPTH             (DEPTH),
                .ALMOST_FULL_SLACK (ALMOST_FULL_SLACK),
                .MAX_ACTIVE_REQS   (MAX_ACTIVE_REQS),
                .CNT_W             (CNT_W)
            ) u_chan (
                .clk               (clk),
                .reset             (reset),
                .i_wrValid         (in_valid[c]),
                .i_wrData          (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
                .i_forceAlmostFull (w_forceAlmostFull),
                .i_outAlmostFull   (out_almost_full[c]),
                .i_retire          (rsp_retire[c]),
                .o_almostFull      (in_almost_full[c]),
                .o_issue           (out_valid[c]),
                .o_issueData       (out_data[c*DATA_WIDTH +: DATA_WIDTH]),
                .o_activeCnt       (active_cnt[c*CNT_W +: CNT_W]),
                .o_idle            (w_chanIdle[c]),
                .o_overflow        (w_chanOverflow[c]),
                .o_underflow       (w_chanUnderflow[c])
            );
        end
    endgenerate

    assign quiesce_ack   = r_quiesceAck;
    assign overflow_err  = r_overflowErr;
    assign underflow_err = r_underflowErr;

    // Quiesce sequencing: a started drain always runs to IDLE even if the request drops.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_RUN:   if (quiesce_req)  w_stateNext = ST_DRAIN;
            ST_DRAIN: if (&w_chanIdle)  w_stateNext = ST_IDLE;
            ST_IDLE:  if (!quiesce_req) w_stateNext = ST_RUN;
            default:  w_stateNext = ST_RUN;
        endcase
    end

    // State register, registered acknowledge and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_quiesceAck   <= 1'b0;
            r_overflowErr  <= 1'b0;
            r_underflowErr <= 1'b0;
        end else begin
            r_state        <= w_stateNext;
            r_quiesceAck   <= (w_stateNext == ST_IDLE);
            r_overflowErr  <= r_overflowErr  | (|w_chanOverflow);
            r_underflowErr <= r_underflowErr | (|w_chanUnderflow);
        end
    end

endmodule

// File: tb/tb_cci_mpf_pipe_req_buf.sv
// Self-checking bench: directed tables and sequences plus random traffic against a queue model.
module tb_cci_mpf_pipe_req_buf;

    localparam int N     = 2;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int SLACK = 8;
    localparam int MAXR  = 4;
    localparam int CW    = $clog2(MAXR + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    in_valid = '0;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]    in_almost_full;
    logic [N-1:0]    out_valid;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_almost_full = '0;
    logic [N-1:0]    rsp_retire = '0;
    logic            quiesce_req = 1'b0;
    logic            quiesce_ack;
    logic [N*CW-1:0] active_cnt;
    logic            overflow_err;
    logic            underflow_err;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model: one queue per channel, outstanding counts, sticky flags, quiesce phase.
    logic [DW-1:0] mq [N][$];
    int            mAct [N];
    bit            mOvf, mUdf, mAck;
    bit   [N-1:0]  mAf;
    int            mPhase;   // 0 running, 1 draining, 2 drained

    typedef struct {
        logic [N-1:0] inValid;
        logic [N-1:0] oaf;
        logic         expAf0;
        logic         expOvf;
    } vec_t;
    vec_t vecs [20];

    cci_mpf_pipe_req_buf #(
        .N_CHANNELS        (N),
        .DATA_WIDTH        (DW),
        .DEPTH             (DEPTH),
        .ALMOST_FULL_SLACK (SLACK),
        .MAX_ACTIVE_REQS   (MAXR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_almost_full  (in_almost_full),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_almost_full (out_almost_full),
        .rsp_retire      (rsp_retire),
        .quiesce_req     (quiesce_req),
        .quiesce_ack     (quiesce_ack),
        .active_cnt      (active_cnt),
        .overflow_err    (overflow_err),
        .underflow_err   (underflow_err)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    endtask

    task automatic modelClear();
        for (int c = 0; c < N; c++) begin
            mq[c].delete();
            mAct[c] = 0;
        end
        mOvf = 0; mUdf = 0; mAck = 0; mAf = '0; mPhase = 0;
    endtask

    // Drive one cycle of inputs, then compare every output with the model before the edge.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                 input logic [N-1:0] oaf, input logic [N-1:0] ret, input logic q);
        logic [N-1:0] expValid;
        in_valid = v; in_data = {d1, d0}; out_almost_full = oaf; rsp_retire = ret; quiesce_req = q;
        #1;
        for (int c = 0; c < N; c++)
            expValid[c] = (mq[c].size() > 0) && !oaf[c] && (mAct[c] < MAXR);
        checkOutput("out_valid", 64'(out_valid), 64'(expValid));
        for (int c = 0; c < N; c++) begin
            if (expValid[c]) checkOutput("out_data", out_data[c*DW +: DW], mq[c][0]);
            checkOutput("active_cnt", 64'(active_cnt[c*CW +: CW]), 64'(mAct[c]));
        end
        checkOutput("in_almost_full", 64'(in_almost_full), 64'(mAf));
        checkOutput("quiesce_ack", 64'(quiesce_ack), 64'(mAck));
        checkOutput("overflow_err", 64'(overflow_err), 64'(mOvf));
        checkOutput("underflow_err", 64'(underflow_err), 64'(mUdf));
    endtask

    // Advance the model by one clock using the inputs currently driven, then move to the next negedge.
    task automatic clockEdge();
        bit allEmpty = 1;
        int sz;
        bit iss;
        for (int c = 0; c < N; c++)
            if (mq[c].size() != 0 || mAct[c] != 0) allEmpty = 0;
        for (int c = 0; c < N; c++) begin
            sz  = mq[c].size();
            iss = (sz > 0) && !out_almost_full[c] && (mAct[c] < MAXR);
            if (iss) void'(mq[c].pop_front());
            if (in_valid[c]) begin
                if (sz < DEPTH || iss) mq[c].push_back(in_data[c*DW +: DW]);
                else mOvf = 1;
            end
            if (iss && !rsp_retire[c]) mAct[c]++;
            else if (!iss && rsp_retire[c]) begin
                if (mAct[c] == 0) mUdf = 1;
                else mAct[c]--;
            end
        end
        if (mPhase == 0 && quiesce_req) mPhase = 1;
        else if (mPhase == 1 && allEmpty) mPhase = 2;
        else if (mPhase == 2 && !quiesce_req) mPhase = 0;
        for (int c = 0; c < N; c++)
            mAf[c] = (mq[c].size() >= DEPTH - SLACK) || (mPhase != 0);
        mAck = (mPhase == 2);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus('0, '0, '0, '0, '0, 1'b0);
        clockEdge();
    endtask

    // Reset pulse between edges; the next posedge is the first normal one.
    task automatic doReset();
        in_valid = '0; rsp_retire = '0; out_almost_full = '0; quiesce_req = 1'b0;
        #2 reset = 1'b1;
        #3 reset = 1'b0;
        modelClear();
        clockEdge();
    endtask

    initial begin
        int issues;
        bit afHigh;
        bit acked;
        logic [DW-1:0] rnd;

        for (int k = 1; k <= 20; k++)
            vecs[k-1] = '{inValid: 2'b01, oaf: 2'b11, expAf0: (k >= 9), expOvf: (k >= 18)};

        modelClear();
        @(negedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 0);
        checkOutput("reset_in_af", 64'(in_almost_full), 0);
        checkOutput("reset_active", 64'(active_cnt), 0);
        checkOutput("reset_ack", 64'(quiesce_ack), 0);
        checkOutput("reset_errs", {62'd0, overflow_err, underflow_err}, 0);
        @(negedge clk);
        doReset();

        // Fill ch0 past full with downstream blocked.
        $display("[TB] fill to overflow");
        for (int i = 0; i < 20; i++) begin
            rnd = {$urandom, $urandom};
            applyStimulus(vecs[i].inValid, rnd, '0, vecs[i].oaf, '0, 1'b0);
            checkOutput("tbl_af0", 64'(in_almost_full[0]), 64'(vecs[i].expAf0));
            checkOutput("tbl_ovf", 64'(overflow_err), 64'(vecs[i].expOvf));
            clockEdge();
        end
        applyStimulus('0, '0, '0, 2'b11, '0, 1'b0);
        checkOutput("fill_final_ovf", 64'(overflow_err), 1);
        checkOutput("fill_final_af", 64'(in_almost_full[0]), 1);
        clockEdge();

        // Single write on ch1 issues the following cycle.
        doReset();
        applyStimulus(2'b10, '0, 64'hA5, '0, '0, 1'b0);
        clockEdge();
        applyStimulus('0, '0, '0, '0, '0, 1'b0);
        checkOutput("a5_valid", 64'(out_valid[1]), 1);
        checkOutput("a5_data", out_data[DW +: DW], 64'hA5);
        clockEdge();
        applyStimulus('0, '0, '0, '0, '0, 1'b0);
        checkOutput("a5_active", 64'(active_cnt[CW +: CW]), 1);
        clockEdge();

        // Outstanding limit: six writes, four issue; two retires release two more.
        doReset();
        issues = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus((i < 6) ? 2'b01 : 2'b00, 64'(i + 1), '0, '0, '0, 1'b0);
            if (out_valid[0]) issues++;
            clockEdge();
        end
        checkOutput("limit_first_issues", 64'(issues), 4);
        checkOutput("limit_active", 64'(active_cnt[0 +: CW]), 4);
        issues = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus('0, '0, '0, '0, (i < 2) ? 2'b01 : 2'b00, 1'b0);
            if (out_valid[0]) issues++;
            clockEdge();
        end
        checkOutput("limit_second_issues", 64'(issues), 2);

        // Issue plus retire at three outstanding holds the count; retire at zero flags underflow.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, 64'(i), '0, '0, '0, 1'b0);
            clockEdge();
        end
        idleCycle();
        applyStimulus(2'b01, 64'h77, '0, '0, '0, 1'b0);
        clockEdge();
        applyStimulus('0, '0, '0, '0, 2'b01, 1'b0);
        checkOutput("same_cycle_issue", 64'(out_valid[0]), 1);
        checkOutput("same_cycle_pre", 64'(active_cnt[0 +: CW]), 3);
        clockEdge();
        applyStimulus('0, '0, '0, '0, '0, 1'b0);
        checkOutput("same_cycle_active", 64'(active_cnt[0 +: CW]), 3);
        clockEdge();
        doReset();
        applyStimulus('0, '0, '0, '0, 2'b10, 1'b0);
        clockEdge();
        applyStimulus('0, '0, '0, '0, '0, 1'b0);
        checkOutput("underflow_flag", 64'(underflow_err), 1);
        checkOutput("underflow_hold", 64'(active_cnt[CW +: CW]), 0);
        clockEdge();

        // Quiesce with two outstanding and three queued.
        doReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b01, 64'(i), '0, '0, '0, 1'b0);
            clockEdge();
        end
        idleCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, 64'(i + 10), '0, 2'b01, '0, 1'b0);
            clockEdge();
        end
        afHigh = 1; acked = 0;
        for (int i = 0; i < 80 && !acked; i++) begin
            applyStimulus('0, '0, '0, (i < 3) ? 2'b01 : 2'b00,
                          (i > 4 && (i % 2 == 0) && mAct[0] > 0) ? 2'b01 : 2'b00, 1'b1);
            if (i > 0 && in_almost_full != 2'b11) afHigh = 0;
            if (quiesce_ack) begin
                acked = 1;
                checkOutput("drain_active_zero", 64'(active_cnt[0 +: CW]), 0);
            end
            clockEdge();
        end
        checkOutput("drain_ack_seen", 64'(acked), 1);
        checkOutput("drain_af_high", 64'(afHigh), 1);
        idleCycle();
        applyStimulus('0, '0, '0, '0, '0, 1'b0);
        checkOutput("resume_ack", 64'(quiesce_ack), 0);
        checkOutput("resume_af", 64'(in_almost_full), 0);
        clockEdge();

        // Asynchronous reset with five queued entries.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b01, 64'(i), '0, 2'b11, '0, 1'b0);
            clockEdge();
        end
        applyStimulus('0, '0, '0, '0, '0, 1'b0);
        checkOutput("pre_reset_valid", 64'(out_valid[0]), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_valid", 64'(out_valid), 0);
        checkOutput("async_af", 64'(in_almost_full), 0);
        checkOutput("async_active", 64'(active_cnt), 0);
        checkOutput("async_flags", {61'd0, quiesce_ack, overflow_err, underflow_err}, 0);
        #2 reset = 1'b0;
        modelClear();
        clockEdge();
        for (int i = 0; i < 5; i++) begin
            applyStimulus('0, '0, '0, '0, '0, 1'b0);
            checkOutput("post_reset_quiet", 64'(out_valid), 0);
            clockEdge();
        end

        // Random traffic against the model.
        $display("[TB] random traffic");
        doReset();
        quiesce_req = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic q;
            q = quiesce_req;
            if ($urandom_range(0, 99) < 3) q = ~q;
            applyStimulus(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                          ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                          2'($urandom) & 2'($urandom), q);
            clockEdge();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
